mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memory/SPI-flash port between core instruction fetch (IF) and core
//  load/store (D). Sits between core and memory; one outstanding transaction at a time.
//  Latches winner's request, drives backend handshake, routes response back to owner.
// PARAMETERS
//  ADDR_W  32  address width
//  DATA_W  32  data width
// PORTS
//  CLK_CPU      in   1       single clock, rising edge
//  resetn       in   1       asynchronous active-low reset
//  if_req       in   1       fetch request; held until if_gnt
//  if_addr      in   ADDR_W  fetch address
//  if_gnt       out  1       fetch request accepted this cycle
//  if_rdata     out  DATA_W  fetch data
//  if_rvalid    out  1       1-cycle pulse, if_rdata valid
//  d_req        in   1       data request; held until d_gnt
//  d_we         in   1       1=store, 0=load
//  d_size       in   2       0=byte 1=half 2=word
//  d_addr       in   ADDR_W  data address
//  d_wdata      in   DATA_W  store data
//  d_gnt        out  1       data request accepted this cycle
//  d_rdata      out  DATA_W  load data
//  d_rvalid     out  1       1-cycle pulse, load data valid
//  d_wdone      out  1       1-cycle pulse, store completed
//  mem_req      out  1       backend request, held until mem_ready
//  mem_we/mem_size/mem_addr/mem_wdata  out  1/2/ADDR_W/DATA_W  registered request fields
//  mem_ready    in   1       backend accepts request this cycle
//  mem_rvalid   in   1       backend read data valid
//  mem_rdata    in   DATA_W  backend read data
//  mem_wdone    in   1       backend write complete
//  busy         out  1       state != IDLE
//  debug        out  32      [1:0]state [2]owner(1=D) [3]err_spurious [15:8]IF grants [23:16]D grants
// BEHAVIOUR
//  - Reset: state IDLE, all outputs 0, request regs 0, grant counters 0, err 0. Memory shares resetn,
//    so no in-flight response survives reset; reset mid-transaction abandons it silently.
//  - FSM IDLE->ISSUE->WAIT->IDLE.
//  - IDLE: if any req, pick winner; gnt is combinational in that cycle (forced 0 in reset);
//    fields captured at that edge; owner<=winner; ->ISSUE. Fetch captures we=0,size=2.
//  - Fixed priority: D beats IF on simultaneous requests.
//  - ISSUE: mem_req=1 from regs. mem_ready -> WAIT. If mem_ready and completion (mem_rvalid read /
//    mem_wdone write) in same cycle -> complete, ->IDLE directly.
//  - WAIT: mem_req=0. Completion -> owner's rdata <= mem_rdata (reads), rvalid/wdone pulse next
//    cycle for exactly 1 cycle; ->IDLE. rdata holds until next read of that owner.
//  - Min latency req->rvalid: 3 cycles with zero-wait backend; 1 IDLE cycle between transactions.
//  - mem_rvalid/mem_wdone in IDLE, or mismatched (wdone for read) -> dropped, err_spurious sticky.
//  - Grant counters 8-bit, wrap 255->0.
//  - Requester changing fields while req held pre-grant: arbiter uses grant-cycle values.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous IF+D, winner = requester not served last
//    (last_owner reg, reset=IF so D wins first tie). Single requester always wins.
//  Undefined: fixed D-over-IF priority; last_owner reg absent.
// STRUCTURE
//  mem_arb_pkg: typedef enum arb_state_t {IDLE,ISSUE,WAIT}; enum owner_t {OWN_IF,OWN_D};
//    SIZE_B/SIZE_H/SIZE_W constants.
//  Sub-module arb_pick: if_req,d_req,last_owner -> winner, any; holds macro-dependent policy.
// TESTING
//  1 IF only, addr 0x100, mem_ready same cycle, rvalid 1 cycle later data 0xDEADBEEF
//    -> if_gnt cyc0, mem_req cyc1, if_rvalid pulse with 0xDEADBEEF, busy low after.
//  2 IF+D same cycle, D load 0x2000 -> d_gnt first, IF granted 1 cycle after D completes;
//    with ARB_ROUND_ROBIN_EN a second tie grants IF first.
//  3 D store size=0 data 0xAB to 0x3001, mem_ready delayed 4 cycles -> mem_req held 4 cycles
//    stable fields, d_wdone single pulse, no d_rvalid.
//  4 mem_ready and mem_rvalid same cycle -> ISSUE->IDLE, rvalid pulse, no WAIT cycle.
//  5 mem_rvalid injected in IDLE -> no rvalid pulse, debug[3]=1 until reset.
//  6 resetn low during WAIT -> all outputs 0 async, state IDLE, counters 0; 256 IF grants wrap debug[15:8] to 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory port arbiter.
//   arb_state_t : transaction FSM states (IDLE -> ISSUE -> WAIT -> IDLE)
//   owner_t     : which requester owns the current transaction
//   SIZE_*      : access size encodings on d_size / mem_size
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [1:0] SIZE_B = 2'd0;
  localparam logic [1:0] SIZE_H = 2'd1;
  localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/arb_pick.sv
// Winner selection between instruction fetch and data requesters.
// Optional feature macro: ARB_ROUND_ROBIN_EN
//   defined   : on a tie, the requester not served last wins (needs last_owner)
//   undefined : fixed priority, data beats fetch
// Ports:
//   last_owner (in, only with ARB_ROUND_ROBIN_EN) owner of the previous grant
//   if_req, d_req (in)  requests
//   winner (out)        selected owner, valid when any is high
//   any (out)           at least one request pending
module arb_pick
  import mem_arb_pkg::*;
(
`ifdef ARB_ROUND_ROBIN_EN
  input  owner_t last_owner,
`endif
  input  logic   if_req,
  input  logic   d_req,
  output owner_t winner,
  output logic   any
);

  always_comb begin
    any    = if_req | d_req;
    winner = OWN_IF;
    if (if_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
      winner = (last_owner == OWN_D) ? OWN_IF : OWN_D;
`else
      winner = OWN_D;
`endif
    end else if (d_req) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between core instruction fetch (IF) and load/store (D).
// One outstanding transaction; the winner's request is latched, driven to the backend,
// and the response is routed back to the owner as a single-cycle pulse.
// Optional feature macro: ARB_ROUND_ROBIN_EN (round-robin tie break, see arb_pick).
// Ports:
//   CLK_CPU, resetn                     clock, async active-low reset
//   if_req/if_addr -> if_gnt/if_rdata/if_rvalid           fetch side
//   d_req/d_we/d_size/d_addr/d_wdata -> d_gnt/d_rdata/d_rvalid/d_wdone   data side
//   mem_req/mem_we/mem_size/mem_addr/mem_wdata, mem_ready/mem_rvalid/mem_rdata/mem_wdone
//   busy   : transaction in progress
//   debug  : [1:0] state, [2] owner, [3] sticky spurious-response flag,
//            [15:8] IF grant count, [23:16] D grant count
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              CLK_CPU,
  input  logic              resetn,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_rvalid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_rvalid,
  output logic              d_wdone,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_wdone,
  output logic              busy,
  output logic [31:0]       debug
);

  arb_state_t        r_state, w_state_next;
  owner_t            r_owner;
  logic              r_we;
  logic [1:0]        r_size;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_if_rdata, r_d_rdata;
  logic              r_if_rvalid, r_d_rvalid, r_d_wdone;
  logic              r_err;
  logic [7:0]        r_if_cnt, r_d_cnt;

  owner_t w_winner;
  logic   w_any, w_grant, w_accept, w_complete, w_spurious;

`ifdef ARB_ROUND_ROBIN_EN
  owner_t r_last_owner;
`endif

  arb_pick u_arb_pick (
`ifdef ARB_ROUND_ROBIN_EN
    .last_owner (r_last_owner),
`endif
    .if_req     (if_req),
    .d_req      (d_req),
    .winner     (w_winner),
    .any        (w_any)
  );

  assign w_grant = (r_state == IDLE) && w_any;
  // Grants are forced low while reset is asserted, even though they are combinational.
  assign if_gnt  = resetn && w_grant && (w_winner == OWN_IF);
  assign d_gnt   = resetn && w_grant && (w_winner == OWN_D);

  // A response is only acceptable once the backend has taken the request (WAIT, or the
  // accepting ISSUE cycle) and only of the kind matching the latched direction.
  assign w_accept   = (r_state == WAIT) || ((r_state == ISSUE) && mem_ready);
  assign w_complete = w_accept && (r_we ? mem_wdone : mem_rvalid);
  assign w_spurious = (mem_rvalid && !(w_accept && !r_we)) ||
                      (mem_wdone && !(w_accept && r_we));

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:    if (w_any) w_state_next = ISSUE;
      ISSUE:   if (w_complete) w_state_next = IDLE;
               else if (mem_ready) w_state_next = WAIT;
      WAIT:    if (w_complete) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      r_state     <= IDLE;
      r_owner     <= OWN_IF;
      r_we        <= 1'b0;
      r_size      <= 2'd0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_if_rdata  <= '0;
      r_d_rdata   <= '0;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_wdone   <= 1'b0;
      r_err       <= 1'b0;
      r_if_cnt    <= 8'd0;
      r_d_cnt     <= 8'd0;
    end else begin
      r_state     <= w_state_next;
      r_if_rvalid <= 1'b0;
      r_d_rvalid  <= 1'b0;
      r_d_wdone   <= 1'b0;
      if (w_spurious) r_err <= 1'b1;
      if (w_grant) begin
        r_owner <= w_winner;
        if (w_winner == OWN_D) begin
          r_we    <= d_we;
          r_size  <= d_size;
          r_addr  <= d_addr;
          r_wdata <= d_wdata;
          r_d_cnt <= r_d_cnt + 8'd1;
        end else begin
          r_we     <= 1'b0;
          r_size   <= SIZE_W;
          r_addr   <= if_addr;
          r_wdata  <= '0;
          r_if_cnt <= r_if_cnt + 8'd1;
        end
      end
      if (w_complete) begin
        if (r_we) begin
          r_d_wdone <= 1'b1;
        end else if (r_owner == OWN_D) begin
          r_d_rdata  <= mem_rdata;
          r_d_rvalid <= 1'b1;
        end else begin
          r_if_rdata  <= mem_rdata;
          r_if_rvalid <= 1'b1;
        end
      end
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  always_ff @(posedge CLK_CPU or negedge resetn) begin
    if (!resetn) begin
      r_last_owner <= OWN_IF;
    end else if (w_grant) begin
      r_last_owner <= w_winner;
    end
  end
`endif

  assign mem_req   = (r_state == ISSUE);
  assign mem_we    = r_we;
  assign mem_size  = r_size;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign if_rdata  = r_if_rdata;
  assign if_rvalid = r_if_rvalid;
  assign d_rdata   = r_d_rdata;
  assign d_rvalid  = r_d_rvalid;
  assign d_wdone   = r_d_wdone;
  assign busy      = (r_state != IDLE);
  assign debug     = {8'd0, r_d_cnt, r_if_cnt, 4'd0, r_err, r_owner, r_state};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter. Inputs change 1 time unit after
// the rising edge; outputs are compared 1 time unit later, well before the next edge.
module tb_mem_port_arbiter;

  logic        CLK_CPU = 1'b0;
  logic        resetn  = 1'b0;
  logic        if_req  = 1'b0;
  logic [31:0] if_addr = '0;
  logic        if_gnt;
  logic [31:0] if_rdata;
  logic        if_rvalid;
  logic        d_req   = 1'b0;
  logic        d_we    = 1'b0;
  logic [1:0]  d_size  = 2'd0;
  logic [31:0] d_addr  = '0;
  logic [31:0] d_wdata = '0;
  logic        d_gnt;
  logic [31:0] d_rdata;
  logic        d_rvalid;
  logic        d_wdone;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_size;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready  = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata  = '0;
  logic        mem_wdone  = 1'b0;
  logic        busy;
  logic [31:0] debug;

  int errors = 0;
  int checks = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .CLK_CPU    (CLK_CPU),
    .resetn     (resetn),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_gnt     (if_gnt),
    .if_rdata   (if_rdata),
    .if_rvalid  (if_rvalid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_gnt      (d_gnt),
    .d_rdata    (d_rdata),
    .d_rvalid   (d_rvalid),
    .d_wdone    (d_wdone),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_size   (mem_size),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ready  (mem_ready),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .mem_wdone  (mem_wdone),
    .busy       (busy),
    .debug      (debug)
  );

  always #5 CLK_CPU = ~CLK_CPU;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK_CPU);
    #1;
  endtask

  // Let combinational outputs settle after input changes.
  task automatic settle();
    #1;
  endtask

  initial begin
    // Reset: outputs idle, grant suppressed even with a request pending.
    if_req = 1'b1;
    if_addr = 32'h100;
    #3;
    check_eq("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
    check_eq("rst_busy", {31'd0, busy}, 32'd0);
    check_eq("rst_debug", debug, 32'd0);
    check_eq("rst_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    tick();
    resetn = 1'b1;

    // 1: IF-only read, zero-wait backend.
    settle();
    check_eq("t1_if_gnt", {31'd0, if_gnt}, 32'd1);
    check_eq("t1_d_gnt", {31'd0, d_gnt}, 32'd0);
    tick();
    if_req = 1'b0;
    settle();
    check_eq("t1_mem_req", {31'd0, mem_req}, 32'd1);
    check_eq("t1_mem_addr", mem_addr, 32'h100);
    check_eq("t1_mem_we_size", {29'd0, mem_we, mem_size}, 32'd2);
    check_eq("t1_state_issue", {30'd0, debug[1:0]}, 32'd1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    settle();
    check_eq("t1_wait_mem_req", {31'd0, mem_req}, 32'd0);
    check_eq("t1_wait_busy", {31'd0, busy}, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("t1_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check_eq("t1_if_rdata", if_rdata, 32'hDEADBEEF);
    check_eq("t1_busy_low", {31'd0, busy}, 32'd0);
    check_eq("t1_if_cnt", {24'd0, debug[15:8]}, 32'd1);
    tick();
    check_eq("t1_rvalid_pulse", {31'd0, if_rvalid}, 32'd0);
    check_eq("t1_rdata_hold", if_rdata, 32'hDEADBEEF);

    // 2: simultaneous IF + D load; D wins (fresh tie under either policy).
    if_req = 1'b1;
    if_addr = 32'h104;
    d_req = 1'b1;
    d_we = 1'b0;
    d_size = 2'd2;
    d_addr = 32'h2000;
    settle();
    check_eq("t2_d_gnt", {31'd0, d_gnt}, 32'd1);
    check_eq("t2_if_gnt", {31'd0, if_gnt}, 32'd0);
    tick();
    d_req = 1'b0;
    settle();
    check_eq("t2_mem_addr", mem_addr, 32'h2000);
    check_eq("t2_owner_d", {31'd0, debug[2]}, 32'd1);
    check_eq("t2_if_wait", {31'd0, if_gnt}, 32'd0);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h11112222;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("t2_d_rvalid", {31'd0, d_rvalid}, 32'd1);
    check_eq("t2_d_rdata", d_rdata, 32'h11112222);
    check_eq("t2_if_no_rvalid", {31'd0, if_rvalid}, 32'd0);
    check_eq("t2_if_gnt_after", {31'd0, if_gnt}, 32'd1);
    tick();
    if_req = 1'b0;
    // 4: mem_ready and mem_rvalid together in ISSUE -> straight back to IDLE.
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h000055AA;
    settle();
    check_eq("t4_mem_addr", mem_addr, 32'h104);
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    settle();
    check_eq("t4_busy", {31'd0, busy}, 32'd0);
    check_eq("t4_if_rvalid", {31'd0, if_rvalid}, 32'd1);
    check_eq("t4_if_rdata", if_rdata, 32'h000055AA);
    check_eq("t4_d_rdata_hold", d_rdata, 32'h11112222);

    // 3: D byte store, backend accepts on the 4th ISSUE cycle.
    d_req = 1'b1;
    d_we = 1'b1;
    d_size = 2'd0;
    d_addr = 32'h3001;
    d_wdata = 32'hAB;
    settle();
    check_eq("t3_d_gnt", {31'd0, d_gnt}, 32'd1);
    tick();
    d_req = 1'b0;
    d_addr = 32'hFFFF_0000;
    d_wdata = 32'h1234_5678;
    d_size = 2'd2;
    for (int i = 0; i < 4; i++) begin
      settle();
      check_eq("t3_mem_req_held", {31'd0, mem_req}, 32'd1);
      check_eq("t3_fields", {mem_addr[15:0], mem_wdata[7:0], 5'd0, mem_we, mem_size},
               {16'h3001, 8'hAB, 5'd0, 1'b1, 2'd0});
      if (i == 3) mem_ready = 1'b1;
      tick();
    end
    mem_ready = 1'b0;
    mem_wdone = 1'b1;
    settle();
    check_eq("t3_wait_mem_req", {31'd0, mem_req}, 32'd0);
    tick();
    mem_wdone = 1'b0;
    settle();
    check_eq("t3_d_wdone", {31'd0, d_wdone}, 32'd1);
    check_eq("t3_no_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
    check_eq("t3_d_cnt", {24'd0, debug[23:16]}, 32'd2);
    tick();
    check_eq("t3_wdone_pulse", {31'd0, d_wdone}, 32'd0);

    // 5: read data with no transaction in flight is dropped and flagged.
    check_eq("t5_err_before", {31'd0, debug[3]}, 32'd0);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hBADBAD00;
    tick();
    mem_rvalid = 1'b0;
    settle();
    check_eq("t5_no_rvalid", {30'd0, d_rvalid, if_rvalid}, 32'd0);
    check_eq("t5_err", {31'd0, debug[3]}, 32'd1);
    check_eq("t5_rdata_hold", if_rdata, 32'h000055AA);

    // Second tie, last served was D: round-robin picks IF, fixed priority picks D.
    if_req = 1'b1;
    if_addr = 32'h108;
    d_req = 1'b1;
    d_we = 1'b0;
    d_addr = 32'h2004;
    settle();
`ifdef ARB_ROUND_ROBIN_EN
    check_eq("tie2_gnt", {30'd0, if_gnt, d_gnt}, 32'd2);
`else
    check_eq("tie2_gnt", {30'd0, if_gnt, d_gnt}, 32'd1);
`endif
    tick();
    if_req = 1'b0;
    d_req = 1'b0;
    mem_ready = 1'b1;
    mem_rvalid = 1'b1;
    tick();
    mem_ready = 1'b0;
    mem_rvalid = 1'b0;
    check_eq("t5_err_sticky", {31'd0, debug[3]}, 32'd1);

    // 6: reset while waiting for the backend.
    if_req = 1'b1;
    if_addr = 32'h200;
    tick();
    if_req = 1'b0;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    settle();
    check_eq("t6_in_wait", {30'd0, debug[1:0]}, 32'd2);
    resetn = 1'b0;
    settle();
    check_eq("t6_busy", {31'd0, busy}, 32'd0);
    check_eq("t6_debug", debug, 32'd0);
    check_eq("t6_rdata", if_rdata | d_rdata, 32'd0);
    check_eq("t6_mem", {mem_addr[29:0], mem_req, mem_we}, 32'd0);
    tick();
    resetn = 1'b1;
    tick();
    check_eq("t6_no_stale", {31'd0, if_rvalid}, 32'd0);

    // 256 fetch grants wrap the IF grant counter.
    for (int n = 1; n <= 256; n++) begin
      if_req = 1'b1;
      tick();
      if_req = 1'b0;
      mem_ready = 1'b1;
      mem_rvalid = 1'b1;
      tick();
      mem_ready = 1'b0;
      mem_rvalid = 1'b0;
      if (n == 255) check_eq("cnt_255", {24'd0, debug[15:8]}, 32'd255);
    end
    check_eq("cnt_wrap", {24'd0, debug[15:8]}, 32'd0);
    check_eq("cnt_d_zero", {24'd0, debug[23:16]}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Bound total run time.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
